// File: rtl/btb_update_scheduler_if.sv
// Bundle of the update, BTB-write and forwarding signals of the BTB update scheduler.
interface btb_update_scheduler_if;
   logic        upd_valid;
   logic [15:0] upd_pc;
   logic [15:0] upd_target;
   logic        upd_taken;
   logic        upd_ready;
   logic        btb_busy;
   logic        wb_enable;
   logic [15:0] wb_pc;
   logic [15:0] wb_target;
   logic        wb_taken;
   logic        fetch_steal;
   logic [15:0] lookup_pc;
   logic        fwd_hit;
   logic [15:0] fwd_target;
   logic        fwd_taken;
   logic [2:0]  count;

   // Scheduler side
   modport slave (
      input  upd_valid, upd_pc, upd_target, upd_taken, btb_busy, lookup_pc,
      output upd_ready, wb_enable, wb_pc, wb_target, wb_taken, fetch_steal,
             fwd_hit, fwd_target, fwd_taken, count
   );

   // Pipeline / BTB side
   modport master (
      output upd_valid, upd_pc, upd_target, upd_taken, btb_busy, lookup_pc,
      input  upd_ready, wb_enable, wb_pc, wb_target, wb_taken, fetch_steal,
             fwd_hit, fwd_target, fwd_taken, count
   );
endinterface

// File: rtl/btb_update_scheduler.sv
// BTB update scheduler: 4-entry coalescing FIFO of resolved-branch updates,
// drained into the shared BTB port when fetch leaves it free, with a one-cycle
// forced steal after prolonged starvation of a full queue.
module btb_update_scheduler (
   input  logic                          clk,
   input  logic                          reset,
   btb_update_scheduler_if.slave         bus
);
   typedef enum logic [1:0] {IDLE, DRAIN, STEAL} state_e;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] target;
      logic        taken;
   } entry_t;

   entry_t     mem_q [4];
   entry_t     mem_d [4];
   logic [1:0] rd_ptr_q, rd_ptr_d;
   logic [1:0] wr_ptr_q, wr_ptr_d;
   logic [2:0] count_q, count_d;
   logic [2:0] starve_q, starve_d;
   state_e     state_q, state_d;

   logic       ready, enq, deq, coalesce, alloc;
   logic [3:0] ent_valid, co_hit;
   logic       fwd_hit;
   logic [15:0] fwd_target;
   logic       fwd_taken;

   // Ready never looks at a same-cycle dequeue, keeping it off the busy path.
   assign ready = (count_q != 3'd4);
   // Steal writes regardless of fetch; otherwise drain only on free cycles.
   assign deq   = (state_q == STEAL) || (state_q == DRAIN && !bus.btb_busy);
   assign enq   = bus.upd_valid && ready;

   // Entry validity from ring position relative to head, plus coalesce match.
   always_comb begin
      ent_valid = '0;
      co_hit    = '0;
      for (int i = 0; i < 4; i++) begin
         ent_valid[i] = ({1'b0, 2'(2'(i) - rd_ptr_q)} < count_q);
         // The head leaving this cycle cannot absorb an update.
         co_hit[i]    = ent_valid[i] && (mem_q[i].pc == bus.upd_pc) &&
                        !(deq && (2'(i) == rd_ptr_q));
      end
   end

   assign coalesce = enq && (|co_hit);
   assign alloc    = enq && !coalesce;

   // Next-state of storage, pointers, occupancy, starvation and FSM.
   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < 4; i++) begin
         if (coalesce && co_hit[i]) begin
            mem_d[i].target = bus.upd_target;
            mem_d[i].taken  = bus.upd_taken;
         end
      end
      if (alloc) mem_d[wr_ptr_q] = '{pc: bus.upd_pc, target: bus.upd_target, taken: bus.upd_taken};

      rd_ptr_d = rd_ptr_q + {1'b0, deq};
      wr_ptr_d = wr_ptr_q + {1'b0, alloc};
      count_d  = count_q + {2'b00, alloc} - {2'b00, deq};

      starve_d = starve_q;
      if (deq || count_q != 3'd4)
         starve_d = 3'd0;
      else if (state_q == DRAIN && bus.btb_busy && starve_q != 3'd7)
         starve_d = starve_q + 3'd1;

      state_d = state_q;
      case (state_q)
         IDLE:  if (enq) state_d = DRAIN;
         DRAIN: begin
            if (starve_q == 3'd7 && count_q == 3'd4 && bus.btb_busy) state_d = STEAL;
            else if (count_d == 3'd0)                                 state_d = IDLE;
         end
         STEAL: state_d = DRAIN;
         default: state_d = IDLE;
      endcase
   end

   // Control state; reset discards every entry by clearing the pointers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         rd_ptr_q <= 2'd0;
         wr_ptr_q <= 2'd0;
         count_q  <= 3'd0;
         starve_q <= 3'd0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         starve_q <= starve_d;
      end
   end

   // Payload storage needs no reset: validity comes from pointers and count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Forward from pending entries; walking head to tail lets the youngest win.
   always_comb begin
      fwd_hit    = 1'b0;
      fwd_target = '0;
      fwd_taken  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if ((3'(k) < count_q) && (mem_q[rd_ptr_q + 2'(k)].pc == bus.lookup_pc)) begin
            fwd_hit    = 1'b1;
            fwd_target = mem_q[rd_ptr_q + 2'(k)].target;
            fwd_taken  = mem_q[rd_ptr_q + 2'(k)].taken;
         end
      end
   end

   assign bus.upd_ready   = ready;
   assign bus.wb_enable   = deq;
   assign bus.fetch_steal = (state_q == STEAL);
   assign bus.wb_pc       = mem_q[rd_ptr_q].pc;
   assign bus.wb_target   = mem_q[rd_ptr_q].target;
   assign bus.wb_taken    = mem_q[rd_ptr_q].taken;
   assign bus.fwd_hit     = fwd_hit;
   assign bus.fwd_target  = fwd_target;
   assign bus.fwd_taken   = fwd_taken;
   assign bus.count       = count_q;
endmodule
